mux_n_pipe: RTL and testbench
=============================

Name: mux_n_pipe

Overview:
- Parametrised successor to the 16-bit 2:1 multiplexor: N channels, W bits each, behind a registered valid/ready output stage.
- Two selection modes, chosen at run time: fixed select and round-robin arbitration among valid channels.
- Sits between multiple producers (ALU result, memory read, I/O) and one consumer that may stall.

Parameters:
- N, 4: number of input channels, N >= 2.
- W, 16: data width per channel, W >= 1.
- SW (localparam), $clog2(N): select and channel-index width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- sel  input  SW  channel index used in mode 0.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out_data  output  W  registered output data.
- out_chan  output  SW  index of the channel that produced out_data.
- out_valid  output  1  output register holds an item.
- out_ready  input  1  consumer accepts the item this cycle.

Behaviour:
- Reset (reset_n low at the edge):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - Round-robin pointer last = N-1, so channel 0 has first priority.
  - Reset overrides any transfer in that cycle; a held item is discarded.
- Output state machine:
  - States EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - space = !out_valid || out_ready.
- Grant (combinational):
  - Mode 0: grant = sel. The grant is valid iff sel < N and in_valid[sel].
  - Mode 1: grant = first i with in_valid[i] set, searching last+1, last+2, ... modulo N. The grant is invalid if no channel is valid.
- Handshake:
  - in_ready[g] = space && grant_valid && (i == g). All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid in mode 1. Producers must not make in_valid depend on in_ready.
- Load: when grant_valid && space:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - In mode 1 only, last <= g.
  - Latency is 1 cycle from the accepting edge to out_valid.
- Drain: when out_valid && out_ready and no load, out_valid <= 0.
  - out_data and out_chan hold their last values.
- Simultaneous drain and load: back-to-back transfer with out_valid staying 1. Sustained throughput is 1 item per cycle.
- Stall: while FULL and out_ready = 0:
  - out_data, out_chan and out_valid are stable.
  - All in_ready bits are 0.
- Mode or sel changes take effect on the next grant computation. They never alter the item already held. last is retained across mode changes.
- sel >= N (non-power-of-2 N): no grant, no load, all in_ready bits 0.
- Round-robin wrap: after granting channel N-1, channel 0 is searched first.

Optional Feature:
- Macro: MUX_N_PIPE_PARITY_EN.
- Defined: adds port out_parity (output, 1 bit) = XOR-reduction of out_data.
  - It is registered alongside out_data, reset to 0, and stable under stall.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0000. Release -> mode 1 grants channel 0 first.
- Fixed select (N = 4, W = 16), mode 0, sel = 2, ch2 = 0xBEEF valid, out_ready = 1 -> in_ready = 0100. Next cycle out_data = 0xBEEF, out_chan = 2, out_valid = 1.
- Round-robin: mode 1, all 4 channels valid, ch i = 0x1000 + i, out_ready = 1 -> out_chan sequence 0, 1, 2, 3, 0. Data 0x1000 to 0x1003 and wrap, one item per cycle.
- Stall: FULL with out_data = 0x00AA and out_ready = 0 for 3 cycles while ch1 is valid -> out_data is stable and in_ready = 0000. Raise out_ready -> ch1 data loads the same cycle the item drains, and out_valid stays 1.
- Sparse round-robin: mode 1, last = 1, only ch0 and ch3 valid -> ch3 is granted, then ch0.
- Parity (macro defined): load 0x0007 -> out_parity = 1. Load 0x0003 -> out_parity = 0.

Source files
------------

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N-channel W-bit multiplexer with registered valid/ready output stage
//
// Purpose:
//   Selects one of N producer channels and loads the chosen item into a
//   single output register. The consumer drains that register through a
//   valid/ready handshake. The channel is chosen by one of two modes:
//     mode 0 : fixed select. The channel is given by sel.
//     mode 1 : round-robin. The search starts at the channel after the
//              last one granted in this mode.
//   An item can be accepted on every cycle in which the output register is
//   empty or is being drained, so the block sustains one item per cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_data    in   N*W flattened channel data; channel i at [i*W +: W]
//   in_valid   in   N   per-channel valid
//   in_ready   out  N   per-channel ready, one-hot or zero
//   sel        in   SW  channel index used in mode 0
//   mode       in   1   0 = fixed select, 1 = round-robin
//   out_data   out  W   registered output data
//   out_chan   out  SW  channel that produced out_data
//   out_valid  out  1   output register holds an item
//   out_ready  in   1   consumer accepts the held item this cycle
//   out_parity out  1   XOR of out_data (only with MUX_N_PIPE_PARITY_EN)
//
// Build option:
//   MUX_N_PIPE_PARITY_EN - when defined, adds the registered out_parity port.

module mux_n_pipe #(
  parameter int N  = 4,
  parameter int W  = 16,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
`ifdef MUX_N_PIPE_PARITY_EN
  ,
  output logic           out_parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state;
  logic [SW-1:0] last;

  logic          space;
  logic          load;

  logic          fixed_valid;
  logic [SW-1:0] rr_grant;
  logic          rr_valid;
  int            rr_dist;
  int            rr_best;

  logic [SW-1:0] grant;
  logic          grant_valid;
  logic [W-1:0]  grant_data;

  assign out_valid = (state == FULL);
  assign space     = (state == EMPTY) || out_ready;
  assign load      = space && grant_valid;

  // Fixed select. Matching sel against every legal index keeps sel >= N
  // (non-power-of-2 N) from selecting anything without an out-of-range index.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        fixed_valid = in_valid[i];
      end
    end
  end

  // Round-robin. rr_dist is the search distance from the channel after
  // last. Channel last+1 has distance 0 and last itself has distance N-1.
  // The valid channel with the smallest distance wins.
  always_comb begin
    rr_grant = '0;
    rr_valid = 1'b0;
    rr_dist  = 0;
    rr_best  = N;
    for (int i = 0; i < N; i++) begin
      rr_dist = (i + N - int'(last) - 1) % N;
      if (in_valid[i] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_grant = SW'(i);
        rr_valid = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = sel;
      grant_valid = fixed_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // Ready is held low during reset. A producer therefore never sees a
  // handshake that the reset discards.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = reset_n && load && (grant == SW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_chan <= '0;
      last     <= SW'(N - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
          end
        end
        FULL: begin
          // A drain with no load empties the register. A drain with a load
          // is a back-to-back transfer, so the register stays FULL.
          if (out_ready && !load) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      if (load) begin
        out_data <= grant_data;
        out_chan <= grant;
        if (mode) begin
          last <= grant;
        end
      end
    end
  end

`ifdef MUX_N_PIPE_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_parity <= 1'b0;
    end else if (load) begin
      out_parity <= ^grant_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - directed self-checking bench for mux_n_pipe

module tb_mux_n_pipe;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = 2;

  logic           clk;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_N_PIPE_PARITY_EN
  logic           out_parity;
`endif

  int checks = 0;
  int errors = 0;

  mux_n_pipe #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_N_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 1'b1;
    sel = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 16'h5A00 + 16'(i));
    in_valid = 4'b1111;
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", in_ready); end
`ifdef MUX_N_PIPE_PARITY_EN
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL reset_parity: got %b want 0", out_parity); end
`endif
    reset_n = 1'b1;
    settle();
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready: got %b want 0001", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_first_chan: got %0d want 0", out_chan); end
    checks++; if (out_data !== 16'h5A00) begin errors++; $display("FAIL reset_first_data: got %h want 5a00", out_data); end
  endtask

  task automatic test_fixed_select();
    do_reset();
    mode = 1'b0;
    sel = 2'd2;
    set_ch(2, 16'hBEEF);
    set_ch(3, 16'h3333);
    in_valid = 4'b0100;
    out_ready = 1'b1;
    settle();
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready: got %b want 0100", in_ready); end
    tick();
    checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL fixed_data: got %h want beef", out_data); end
    checks++; if (out_chan !== 2'd2) begin errors++; $display("FAIL fixed_chan: got %0d want 2", out_chan); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid: got %b want 1", out_valid); end
    sel = 2'd3;
    settle();
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_sel_idle_ready: got %b want 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'hBEEF) begin errors++; $display("FAIL fixed_drain_hold: got %h want beef", out_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 16'h1000 + 16'(i));
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (in_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << (k % 4)); end
      tick();
      checks++; if (out_chan !== 2'(k % 4)) begin errors++; $display("FAIL rr_chan[%0d]: got %0d want %0d", k, out_chan, k % 4); end
      checks++; if (out_data !== 16'h1000 + 16'(k % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", k, out_data, 16'h1000 + 16'(k % 4)); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b want 1", k, out_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    mode = 1'b0;
    sel = 2'd0;
    set_ch(0, 16'h00AA);
    set_ch(1, 16'h0BB1);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    tick();
    checks++; if (out_data !== 16'h00AA) begin errors++; $display("FAIL stall_load: got %h want 00aa", out_data); end
    in_valid = 4'b0010;
    sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, in_ready); end
      tick();
      checks++; if (out_data !== 16'h00AA) begin errors++; $display("FAIL stall_data[%0d]: got %h want 00aa", k, out_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL stall_chan[%0d]: got %0d want 0", k, out_chan); end
    end
    out_ready = 1'b1;
    settle();
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL stall_release_ready: got %b want 0010", in_ready); end
    tick();
    checks++; if (out_data !== 16'h0BB1) begin errors++; $display("FAIL b2b_data: got %h want 0bb1", out_data); end
    checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL b2b_chan: got %0d want 1", out_chan); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0BB1) begin errors++; $display("FAIL stall_drain_hold: got %h want 0bb1", out_data); end
  endtask

  task automatic test_sparse_rr();
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 16'h2000 + 16'(i));
    out_ready = 1'b1;
    in_valid = 4'b0010;
    tick();
    checks++; if (out_chan !== 2'd1) begin errors++; $display("FAIL sparse_setup_chan: got %0d want 1", out_chan); end
    in_valid = 4'b1001;
    settle();
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL sparse_ready_a: got %b want 1000", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd3) begin errors++; $display("FAIL sparse_chan_a: got %0d want 3", out_chan); end
    checks++; if (out_data !== 16'h2003) begin errors++; $display("FAIL sparse_data_a: got %h want 2003", out_data); end
    settle();
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL sparse_ready_b: got %b want 0001", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL sparse_chan_b: got %0d want 0", out_chan); end
    checks++; if (out_data !== 16'h2000) begin errors++; $display("FAIL sparse_data_b: got %h want 2000", out_data); end
    in_valid = 4'b0000;
    settle();
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL sparse_idle_ready: got %b want 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sparse_idle_valid: got %b want 0", out_valid); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL sparse_idle_chan: got %0d want 0", out_chan); end
  endtask

`ifdef MUX_N_PIPE_PARITY_EN
  task automatic test_parity();
    do_reset();
    mode = 1'b0;
    sel = 2'd0;
    out_ready = 1'b1;
    in_valid = 4'b0001;
    set_ch(0, 16'h0007);
    tick();
    checks++; if (out_parity !== 1'b1) begin errors++; $display("FAIL parity_0007: got %b want 1", out_parity); end
    set_ch(0, 16'h0003);
    tick();
    checks++; if (out_parity !== 1'b0) begin errors++; $display("FAIL parity_0003: got %b want 0", out_parity); end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_stall();
    test_sparse_rr();
`ifdef MUX_N_PIPE_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
